bw_multiply: RTL and testbench



---
 rtl/bw_multiply_pkg.sv | 25 ++
 rtl/bw_pp_row.sv | 34 +++
 rtl/bw_multiply.sv | 136 +++++++++++++
 tb/tb_bw_multiply.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bw_multiply_pkg.sv
// bw_multiply_pkg
//   Shared helpers for the Baugh-Wooley multiplier slice:
//   - bw_min / bw_max : pick the row operand (narrower) and the row
//                       operand's partner (wider) widths.
//   - bw_term         : one Baugh-Wooley bit term (AND, or NAND when exactly
//                       one of the two bits is a sign bit).
//   No ports; imported by bw_multiply and bw_pp_row.
package bw_multiply_pkg;

  function automatic int bw_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int bw_max(input int a, input int b);
    return (a < b) ? b : a;
  endfunction

  // Exactly one sign bit in the pair inverts the AND term (NAND). When both
  // or neither are sign bits the plain AND is kept.
  function automatic logic bw_term(input logic m_bit, input logic r_bit,
                                   input logic m_sign, input logic r_sign);
    return (m_bit & r_bit) ^ (m_sign ^ r_sign);
  endfunction

endpackage

// File: rtl/bw_pp_row.sv
// bw_pp_row
//   Combinational generator for one Baugh-Wooley partial-product row.
//   The row is the wide operand m gated bit-by-bit with one bit of the
//   narrow (row) operand, sign-pair terms inverted, zero-extended to P bits
//   and shifted left by ROW.
// Ports
//   m      in   M_WIDTH  wide signed operand (bit M_WIDTH-1 is its sign)
//   r_bit  in   1        bit ROW of the narrow operand
//   row    out  P        shifted partial-product row (modulo 2^P)
module bw_pp_row
  import bw_multiply_pkg::*;
#(
  parameter int M_WIDTH  = 8,
  parameter int P        = 14,
  parameter int ROW      = 0,
  parameter bit LAST_ROW = 1'b0   // r_bit is the narrow operand's sign bit
) (
  input  logic [M_WIDTH-1:0] m,
  input  logic               r_bit,
  output logic [P-1:0]       row
);

  logic [M_WIDTH-1:0] terms;

  always_comb begin
    terms = '0;
    for (int i = 0; i < M_WIDTH; i++) begin
      terms[i] = bw_term(m[i], r_bit, (i == M_WIDTH - 1), LAST_ROW);
    end
  end

  assign row = {{(P - M_WIDTH){1'b0}}, terms} << ROW;

endmodule

// File: rtl/bw_multiply.sv
// bw_multiply
//   Pipelined signed two's-complement multiplier, operands of different
//   widths. Layer 0 registers the Baugh-Wooley partial-product rows (one
//   per bit of the narrower operand, in_B when widths are equal) with the
//   correction constant folded into row 0. Layers 1..L form a registered
//   binary adder tree; out_C is the root. One product per clock, latency
//   L+1 clocks, no stall.
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high; clears all stages
//   in_valid   in   1        in_A/in_B carry an operand pair this cycle
//   in_A       in   A_WIDTH  signed multiplicand
//   in_B       in   B_WIDTH  signed multiplier
//   out_valid  out  1        out_C holds a valid product
//   out_C      out  P        signed product in_A*in_B (exact)
//
// Valid semantics: there is no ready. A pair is accepted on every rising
// edge where in_valid=1 and reset=0; its product appears on out_C with
// out_valid=1 exactly L+1 edges later. in_valid seen during reset is
// dropped. out_C is deterministic but meaningless while out_valid=0.
module bw_multiply
  import bw_multiply_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [A_WIDTH-1:0]         in_A,
  input  logic [B_WIDTH-1:0]         in_B,
  output logic                       out_valid,
  output logic [A_WIDTH+B_WIDTH-1:0] out_C
);

  localparam int S = bw_min(A_WIDTH, B_WIDTH);  // partial-product rows
  localparam int W = bw_max(A_WIDTH, B_WIDTH);  // wide operand width
  localparam int L = $clog2(S);                 // adder-tree layers
  localparam int P = A_WIDTH + B_WIDTH;         // product width

  // Sum of the constants that turn the inverted sign-pair terms back into
  // the subtractions of a signed product: 2^(P-1) + 2^(A-1) + 2^(B-1).
  localparam logic [P-1:0] CORR = (P'(1) << (P - 1))
                                + (P'(1) << (A_WIDTH - 1))
                                + (P'(1) << (B_WIDTH - 1));

  logic [S-1:0] row_op;
  logic [W-1:0] mul_op;
  logic [P-1:0] row_pp [S];

  logic [P-1:0] middle_layers [0:L][0:S-1];
  logic [L:0]   valid_sr;

  // The narrower operand supplies the rows; ties go to in_B.
  generate
    if (A_WIDTH < B_WIDTH) begin : g_row_a
      assign row_op = in_A;
      assign mul_op = in_B;
    end else begin : g_row_b
      assign row_op = in_B;
      assign mul_op = in_A;
    end
  endgenerate

  generate
    for (genvar j = 0; j < S; j++) begin : g_rows
      bw_pp_row #(
        .M_WIDTH  (W),
        .P        (P),
        .ROW      (j),
        .LAST_ROW (j == S - 1)
      ) u_row (
        .m     (mul_op),
        .r_bit (row_op[j]),
        .row   (row_pp[j])
      );
    end
  endgenerate

  // Layer 0: registered partial products, correction folded into row 0.
  generate
    for (genvar j = 0; j < S; j++) begin : g_l0
      localparam logic [P-1:0] ADD = (j == 0) ? CORR : '0;
      always_ff @(posedge clk) begin
        if (reset) begin
          middle_layers[0][j] <= '0;
        end else begin
          middle_layers[0][j] <= row_pp[j] + ADD;
        end
      end
    end
  endgenerate

  // Layers 1..L: pairwise sums. Entries past the live count of a layer
  // only ever see zero sources, so they stay at zero after reset.
  generate
    for (genvar k = 1; k <= L; k++) begin : g_tree
      for (genvar i = 0; i < S; i++) begin : g_ent
        if (2 * i + 1 < S) begin : g_pair
          always_ff @(posedge clk) begin
            if (reset) begin
              middle_layers[k][i] <= '0;
            end else begin
              middle_layers[k][i] <= middle_layers[k-1][2*i] + middle_layers[k-1][2*i+1];
            end
          end
        end else if (2 * i < S) begin : g_single
          // Odd entry with no partner passes through unchanged.
          always_ff @(posedge clk) begin
            if (reset) begin
              middle_layers[k][i] <= '0;
            end else begin
              middle_layers[k][i] <= middle_layers[k-1][2*i];
            end
          end
        end else begin : g_zero
          always_ff @(posedge clk) begin
            middle_layers[k][i] <= '0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_sr <= '0;
    end else begin
      valid_sr <= {valid_sr[L-1:0], in_valid};
    end
  end

  assign out_C     = middle_layers[L][0];
  assign out_valid = valid_sr[L];

endmodule

// File: tb/tb_bw_multiply.sv
// tb_bw_multiply
//   Three multipliers (8x6, 6x8, 5x5) share clock, reset and in_valid.
//   Directed corners use hand-computed products for the 8x6/6x8 pair;
//   the 5x5 unit and the random phase use a signed multiply model.
module tb_bw_multiply;

  localparam int LAT0 = $clog2(6) + 1;
  localparam int LAT1 = $clog2(6) + 1;
  localparam int LAT2 = $clog2(5) + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic in_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  in_A0;
  logic [5:0]  in_B0;
  logic        out_valid0;
  logic [13:0] out_C0;

  logic [5:0]  in_A1;
  logic [7:0]  in_B1;
  logic        out_valid1;
  logic [13:0] out_C1;

  logic [4:0]  in_A2;
  logic [4:0]  in_B2;
  logic        out_valid2;
  logic [9:0]  out_C2;

  bw_multiply #(.A_WIDTH(8), .B_WIDTH(6)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_A(in_A0), .in_B(in_B0), .out_valid(out_valid0), .out_C(out_C0)
  );

  bw_multiply #(.A_WIDTH(6), .B_WIDTH(8)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_A(in_A1), .in_B(in_B1), .out_valid(out_valid1), .out_C(out_C1)
  );

  bw_multiply #(.A_WIDTH(5), .B_WIDTH(5)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_A(in_A2), .in_B(in_B2), .out_valid(out_valid2), .out_C(out_C2)
  );

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q0[$];
  logic [13:0] exp_q1[$];
  logic [9:0]  exp_q2[$];
  logic [15:0] vhist;   // accepted-valid history, bit n = accepted n+1 edges ago
  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] model5(input logic [4:0] a, input logic [4:0] b);
    logic signed [9:0] p;
    p = 10'($signed(a)) * 10'($signed(b));
    return p;
  endfunction

  function automatic logic [13:0] model86(input logic [7:0] a, input logic [5:0] b);
    logic signed [13:0] p;
    p = 14'($signed(a)) * 14'($signed(b));
    return p;
  endfunction

  task automatic monitor(input logic rst_s);
    logic [13:0] e14;
    logic [9:0]  e10;
    if (rst_s) begin
      chk("rst_valid0", 32'(out_valid0), 32'd0);
      chk("rst_out0",   32'(out_C0),     32'd0);
      chk("rst_valid1", 32'(out_valid1), 32'd0);
      chk("rst_out1",   32'(out_C1),     32'd0);
      chk("rst_valid2", 32'(out_valid2), 32'd0);
      chk("rst_out2",   32'(out_C2),     32'd0);
    end else begin
      chk("valid0", 32'(out_valid0), 32'(vhist[LAT0-1]));
      if (vhist[LAT0-1]) begin
        e14 = (exp_q0.size() > 0) ? exp_q0.pop_front() : 14'hxxxx;
        chk("prod0", 32'(out_C0), 32'(e14));
      end
      chk("valid1", 32'(out_valid1), 32'(vhist[LAT1-1]));
      if (vhist[LAT1-1]) begin
        e14 = (exp_q1.size() > 0) ? exp_q1.pop_front() : 14'hxxxx;
        chk("prod1", 32'(out_C1), 32'(e14));
      end
      chk("valid2", 32'(out_valid2), 32'(vhist[LAT2-1]));
      if (vhist[LAT2-1]) begin
        e10 = (exp_q2.size() > 0) ? exp_q2.pop_front() : 10'hxxx;
        chk("prod2", 32'(out_C2), 32'(e10));
      end
    end
  endtask

  task automatic step();
    logic rst_s;
    logic smp_v;
    rst_s = reset;
    smp_v = in_valid && !reset;
    if (rst_s) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
    end
    @(posedge clk);
    vhist = rst_s ? 16'd0 : {vhist[14:0], smp_v};
    #1;
    monitor(rst_s);
  endtask

  // ---------------- driver tasks ----------------
  // exp86 is the product of a (8-bit) and b (6-bit); the 6x8 unit gets the
  // same pair swapped, the 5x5 unit gets its own pair.
  task automatic drive(input logic v, input logic [7:0] a, input logic [5:0] b,
                       input logic [13:0] exp86, input logic [4:0] a2, input logic [4:0] b2);
    in_valid = v;
    in_A0 = a;  in_B0 = b;
    in_A1 = b;  in_B1 = a;
    in_A2 = a2; in_B2 = b2;
    if (v && !reset) begin
      exp_q0.push_back(exp86);
      exp_q1.push_back(exp86);
      exp_q2.push_back(model5(a2, b2));
    end
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)), 14'd0,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
  endtask

  task automatic drive_rand();
    logic [7:0] a;
    logic [5:0] b;
    a = 8'($urandom_range(0, 255));
    b = 6'($urandom_range(0, 63));
    drive(($urandom_range(0, 3) != 0), a, b, model86(a, b),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    vhist    = '0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_A0 = '0; in_B0 = '0; in_A1 = '0; in_B1 = '0; in_A2 = '0; in_B2 = '0;

    // reset for two clocks (in_valid high on the second is dropped)
    step();
    in_valid = 1'b1;
    step();
    reset = 1'b0;

    // 3 * -2 held: -6 = 14'h3FFA; 5x5 unit gets 3 * -2 too
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h03, 6'h3E, 14'h3FFA, 5'h03, 5'h1E);
    idle(5);

    // corners back-to-back
    drive(1'b1, 8'h7F, 6'h1F, 14'h0F61, 5'h0F, 5'h0F);   //  127 *  31 =  3937
    drive(1'b1, 8'h80, 6'h1F, 14'h3080, 5'h10, 5'h0F);   // -128 *  31 = -3968
    drive(1'b1, 8'h7F, 6'h20, 14'h3020, 5'h0F, 5'h10);   //  127 * -32 = -4064
    drive(1'b1, 8'h80, 6'h20, 14'h1000, 5'h10, 5'h10);   // -128 * -32 =  4096
    drive(1'b1, 8'h00, 6'h20, 14'h0000, 5'h00, 5'h10);   //    0 * -32 =     0
    idle(6);

    // three in flight, then reset: none may emerge
    drive(1'b1, 8'h05, 6'h07, 14'h0023, 5'h05, 5'h07);
    drive(1'b1, 8'hFB, 6'h07, 14'h3FDD, 5'h1B, 5'h07);
    drive(1'b1, 8'h11, 6'h3F, 14'h3FEF, 5'h11, 5'h1F);
    reset = 1'b1;
    drive(1'b1, 8'h22, 6'h02, 14'h0044, 5'h02, 5'h02);
    reset = 1'b0;
    idle(6);

    // in_valid pattern 1,0,1,1,0
    drive(1'b1, 8'h09, 6'h03, 14'h001B, 5'h09, 5'h03);
    drive(1'b0, 8'h00, 6'h00, 14'h0000, 5'h00, 5'h00);
    drive(1'b1, 8'hFF, 6'h3F, 14'h0001, 5'h1F, 5'h1F);
    drive(1'b1, 8'h40, 6'h10, 14'h0400, 5'h08, 5'h08);
    drive(1'b0, 8'h00, 6'h00, 14'h0000, 5'h00, 5'h00);
    idle(6);

    // random pairs against the signed multiply model
    for (int i = 0; i < 10000; i++) drive_rand();
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
